// File: rtl/bcd_key_entry.sv
// rtl/bcd_key_entry.sv - keypad operand entry and result capture for the BCD sign-magnitude ALU
// Optional feature macro: BCD_NEG_ZERO_CLR_EN (clears the sign of a zero result).
module bcd_key_entry #(
    parameter int NDIG = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic [4*NDIG-1:0]   alu_s,
    input  logic                alu_flag_s,
    input  logic                alu_flag_ov,
    output logic [4*NDIG-1:0]   a,
    output logic [4*NDIG-1:0]   b,
    output logic                s_a,
    output logic                s_b,
    output logic                op,
    output logic [4*NDIG-1:0]   disp,
    output logic                disp_neg,
    output logic                err,
    output logic                res_valid
);

    localparam int W = 4 * NDIG;
    localparam logic [3:0] CNT_MAX = 4'(NDIG);

    localparam logic [1:0] ST_ENTER_A = 2'd0;
    localparam logic [1:0] ST_ENTER_B = 2'd1;
    localparam logic [1:0] ST_RESULT  = 2'd2;
    localparam logic [1:0] ST_ERROR   = 2'd3;

    localparam logic [3:0] K_PLUS  = 4'd10;
    localparam logic [3:0] K_MINUS = 4'd11;
    localparam logic [3:0] K_EQ    = 4'd12;
    localparam logic [3:0] K_CLR   = 4'd13;
    localparam logic [3:0] K_SIGN  = 4'd14;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic         s_a_q, s_a_d, s_b_q, s_b_d, op_q, op_d, r_neg_q, r_neg_d;
    logic [3:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic         b_ent_q, b_ent_d;
    logic         res_valid_q, res_valid_d;

    logic         is_digit, is_op, new_op, acc_a, acc_b, res_neg;

    // Count of significant digits, so a fed-back result keeps the 8-digit limit honest.
    function automatic logic [3:0] sig_digits(input logic [W-1:0] v);
        sig_digits = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] != 4'd0) sig_digits = 4'(i + 1);
        end
    endfunction

`ifdef BCD_NEG_ZERO_CLR_EN
    assign res_neg = alu_flag_s && (alu_s != '0);
`else
    assign res_neg = alu_flag_s;
`endif

    assign is_digit = (key_code <= 4'd9);
    assign is_op    = (key_code == K_PLUS) || (key_code == K_MINUS);
    assign new_op   = (key_code == K_MINUS);
    assign acc_a    = (cnt_a_q < CNT_MAX) && !((key_code == 4'd0) && (a_q == '0));
    assign acc_b    = (cnt_b_q < CNT_MAX) && !((key_code == 4'd0) && (b_q == '0));

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        s_a_d       = s_a_q;
        s_b_d       = s_b_q;
        op_d        = op_q;
        r_neg_d     = r_neg_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        b_ent_d     = b_ent_q;
        res_valid_d = 1'b0;

        if (key_valid) begin
            if (key_code == K_CLR) begin
                state_d = ST_ENTER_A;
                a_d     = '0;
                b_d     = '0;
                r_d     = '0;
                s_a_d   = 1'b0;
                s_b_d   = 1'b0;
                op_d    = 1'b0;
                r_neg_d = 1'b0;
                cnt_a_d = 4'd0;
                cnt_b_d = 4'd0;
                b_ent_d = 1'b0;
            end else begin
                case (state_q)
                    ST_ENTER_A: begin
                        if (is_digit) begin
                            if (acc_a) begin
                                a_d     = {a_q[W-5:0], key_code};
                                cnt_a_d = cnt_a_q + 4'd1;
                            end
                        end else if (key_code == K_SIGN) begin
                            s_a_d = ~s_a_q;
                        end else if (is_op) begin
                            op_d    = new_op;
                            state_d = ST_ENTER_B;
                        end
                    end
                    ST_ENTER_B: begin
                        if (is_digit) begin
                            b_ent_d = 1'b1;
                            if (acc_b) begin
                                b_d     = {b_q[W-5:0], key_code};
                                cnt_b_d = cnt_b_q + 4'd1;
                            end
                        end else if (key_code == K_SIGN) begin
                            s_b_d = ~s_b_q;
                        end else if (is_op && !b_ent_q) begin
                            op_d = new_op;
                        end else if (is_op || (key_code == K_EQ)) begin
                            // ALU inputs were settled by the previous edge, so capture now.
                            r_d         = alu_s;
                            r_neg_d     = res_neg;
                            res_valid_d = 1'b1;
                            if (alu_flag_ov) begin
                                state_d = ST_ERROR;
                            end else if (is_op) begin
                                a_d     = alu_s;
                                s_a_d   = res_neg;
                                cnt_a_d = sig_digits(alu_s);
                                b_d     = '0;
                                s_b_d   = 1'b0;
                                cnt_b_d = 4'd0;
                                b_ent_d = 1'b0;
                                op_d    = new_op;
                            end else begin
                                state_d = ST_RESULT;
                            end
                        end
                    end
                    ST_RESULT: begin
                        if (is_digit) begin
                            state_d = ST_ENTER_A;
                            a_d     = {{(W-4){1'b0}}, key_code};
                            cnt_a_d = (key_code != 4'd0) ? 4'd1 : 4'd0;
                            b_d     = '0;
                            r_d     = '0;
                            s_a_d   = 1'b0;
                            s_b_d   = 1'b0;
                            op_d    = 1'b0;
                            r_neg_d = 1'b0;
                            cnt_b_d = 4'd0;
                            b_ent_d = 1'b0;
                        end else if (is_op || (key_code == K_SIGN)) begin
                            a_d     = r_q;
                            cnt_a_d = sig_digits(r_q);
                            b_d     = '0;
                            s_b_d   = 1'b0;
                            cnt_b_d = 4'd0;
                            b_ent_d = 1'b0;
                            if (is_op) begin
                                s_a_d   = r_neg_q;
                                op_d    = new_op;
                                state_d = ST_ENTER_B;
                            end else begin
                                s_a_d   = ~r_neg_q;
                                state_d = ST_ENTER_A;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ENTER_A;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            s_a_q       <= 1'b0;
            s_b_q       <= 1'b0;
            op_q        <= 1'b0;
            r_neg_q     <= 1'b0;
            cnt_a_q     <= 4'd0;
            cnt_b_q     <= 4'd0;
            b_ent_q     <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            s_a_q       <= s_a_d;
            s_b_q       <= s_b_d;
            op_q        <= op_d;
            r_neg_q     <= r_neg_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            b_ent_q     <= b_ent_d;
            res_valid_q <= res_valid_d;
        end
    end

    always_comb begin
        disp     = a_q;
        disp_neg = s_a_q;
        case (state_q)
            ST_ENTER_B: begin
                if (b_ent_q) begin
                    disp     = b_q;
                    disp_neg = s_b_q;
                end
            end
            ST_RESULT: begin
                disp     = r_q;
                disp_neg = r_neg_q;
            end
            ST_ERROR: begin
                disp     = {NDIG{4'hE}};
                disp_neg = 1'b0;
            end
            default: ;
        endcase
    end

    assign a         = a_q;
    assign b         = b_q;
    assign s_a       = s_a_q;
    assign s_b       = s_b_q;
    assign op        = op_q;
    assign err       = (state_q == ST_ERROR);
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_bcd_key_entry.sv
// tb/tb_bcd_key_entry.sv - directed self-checking bench for bcd_key_entry with a behavioural BCD ALU
module tb_bcd_key_entry;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] alu_s;
    logic        alu_flag_s;
    logic        alu_flag_ov;
    logic [31:0] a, b, disp;
    logic        s_a, s_b, op, disp_neg, err, res_valid;

    int checks = 0;
    int errors = 0;
    logic neg_zero = 1'b0;
    logic exp_nz;

    longint va, vb, vr, mag;

    bcd_key_entry #(.NDIG(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .alu_s      (alu_s),
        .alu_flag_s (alu_flag_s),
        .alu_flag_ov(alu_flag_ov),
        .a          (a),
        .b          (b),
        .s_a        (s_a),
        .s_b        (s_b),
        .op         (op),
        .disp       (disp),
        .disp_neg   (disp_neg),
        .err        (err),
        .res_valid  (res_valid)
    );

    always #5 clk = ~clk;

    function automatic longint bcd2int(input logic [31:0] v);
        longint r = 0;
        for (int i = 7; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(input longint m);
        logic [31:0] v = '0;
        longint t = m;
        for (int i = 0; i < 8; i++) begin
            v[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return v;
    endfunction

    // Sign-magnitude ALU behaviour; neg_zero lets the bench emulate an ALU reporting -0.
    always_comb begin
        va = bcd2int(a);
        vb = bcd2int(b);
        if (s_a) va = -va;
        if (s_b) vb = -vb;
        vr = op ? (va - vb) : (va + vb);
        mag = (vr < 0) ? -vr : vr;
        alu_flag_s  = (vr < 0) || ((vr == 0) && neg_zero);
        alu_flag_ov = (mag > 64'd99999999);
        alu_s       = int2bcd(mag % 100000000);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".a"}, a, 32'h0);
        check({tag, ".b"}, b, 32'h0);
        check({tag, ".flags"}, {27'h0, s_a, s_b, op, err, res_valid}, 32'h0);
        check({tag, ".disp"}, disp, 32'h0);
        check({tag, ".disp_neg"}, {31'h0, disp_neg}, 32'h0);
    endtask

    task automatic key(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'd15;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        key_valid = 1'b0;
        key_code = 4'd15;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        idle();

        // 12 + 34 = 46
        key(1); key(2);
        check("t1.a", a, 32'h12);
        key(10);
        check("t1.disp_noB", disp, 32'h12);
        key(3); key(4);
        check("t1.dispB", disp, 32'h34);
        key(12);
        check("t1.a_eq", a, 32'h12);
        check("t1.b_eq", b, 32'h34);
        check("t1.op", {31'h0, op}, 32'h0);
        check("t1.disp", disp, 32'h46);
        check("t1.neg", {31'h0, disp_neg}, 32'h0);
        check("t1.rv1", {31'h0, res_valid}, 32'h1);
        idle();
        check("t1.rv0", {31'h0, res_valid}, 32'h0);
        key(12);
        check("t1.eq_ignored", disp, 32'h46);
        key(7);
        check("t1.newA", a, 32'h7);
        check("t1.newB", b, 32'h0);
        check("t1.newdisp", disp, 32'h7);

        // digit limit and leading zeros
        key(13);
        check_zero("clr1");
        for (int d = 1; d <= 9; d++) key(4'(d));
        check("t2.sat", a, 32'h12345678);
        key(13);
        key(0); key(0); key(5);
        check("t2.lz", a, 32'h5);
        for (int d = 1; d <= 7; d++) key(4'(d));
        check("t2.lz_full", a, 32'h51234567);
        key(8);
        check("t2.lz_sat", a, 32'h51234567);

        // 5 - 8 = -3, then + 2 = -1, then sign toggle
        key(13);
        key(5); key(11); key(8); key(12);
        check("t3.disp", disp, 32'h3);
        check("t3.neg", {31'h0, disp_neg}, 32'h1);
        key(10);
        check("t3.fb_a", a, 32'h3);
        check("t3.fb_sa", {31'h0, s_a}, 32'h1);
        check("t3.fb_b", b, 32'h0);
        check("t3.fb_rv", {31'h0, res_valid}, 32'h0);
        key(2); key(12);
        check("t3.disp2", disp, 32'h1);
        check("t3.neg2", {31'h0, disp_neg}, 32'h1);
        key(14);
        check("t3.tog_a", a, 32'h1);
        check("t3.tog_neg", {31'h0, disp_neg}, 32'h0);
        key(5);
        check("t3.tog_dig", a, 32'h15);

        // op replacement with no B digit, then chained eval using the old op
        key(13);
        key(5); key(10); key(11);
        check("t4.op_repl", {31'h0, op}, 32'h1);
        check("t4.no_rv", {31'h0, res_valid}, 32'h0);
        key(3); key(10);
        check("t4.chain_a", a, 32'h2);
        check("t4.chain_op", {31'h0, op}, 32'h0);
        check("t4.chain_rv", {31'h0, res_valid}, 32'h1);
        check("t4.chain_disp", disp, 32'h2);
        key(4); key(12);
        check("t4.chain_res", disp, 32'h6);

        // overflow into ERROR
        key(13);
        for (int i = 0; i < 8; i++) key(9);
        key(10); key(1); key(12);
        check("t5.err", {31'h0, err}, 32'h1);
        check("t5.disp", disp, 32'hEEEEEEEE);
        check("t5.rv", {31'h0, res_valid}, 32'h1);
        key(5);
        check("t5.dig_ign", disp, 32'hEEEEEEEE);
        check("t5.err_hold", {31'h0, err}, 32'h1);
        key(13);
        check_zero("t5.clr");
        key(3);
        check("t5.enterA", a, 32'h3);

        // -7 - (-7) with the ALU reporting negative zero
        key(13);
        neg_zero = 1'b1;
        key(14); key(7); key(11); key(14); key(7);
        check("t6.sb", {31'h0, s_b}, 32'h1);
        key(12);
`ifdef BCD_NEG_ZERO_CLR_EN
        exp_nz = 1'b0;
`else
        exp_nz = 1'b1;
`endif
        check("t6.disp", disp, 32'h0);
        check("t6.negzero", {31'h0, disp_neg}, {31'h0, exp_nz});
        neg_zero = 1'b0;

        // asynchronous reset between keys, then a key on the first edge after release
        key(13);
        key(4);
        check("t7.pre", a, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check_zero("t7.async");
        @(negedge clk);
        rst_n = 1'b1;
        key(11);
        check("t7.first_key", {31'h0, op}, 32'h1);
        key(7);
        check("t7.b", b, 32'h7);
        check("t7.a", a, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
